// File: rtl/csa_seq_multiplier.sv
// Sequential radix-2 multiplier: one carry-save 3:2 row per cycle, then a single
// carry-propagate cycle. Supports unsigned and two's-complement operands.
module csa_seq_multiplier #(
    parameter int DATA_SIZE_x = 8,
    parameter int DATA_SIZE_y = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic                               signed_i,
    input  logic [DATA_SIZE_x-1:0]             x_i,
    input  logic [DATA_SIZE_y-1:0]             y_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [DATA_SIZE_x+DATA_SIZE_y-1:0] p_o,
    output logic [1:0]                         state_o
);

    localparam int W  = DATA_SIZE_x + DATA_SIZE_y;
    localparam int CW = $clog2(DATA_SIZE_y + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid_o holds and p_o stays stable until ready_i is seen.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           sum_q, sum_d;
    logic [W-1:0]           carry_q, carry_d;
    logic [W-1:0]           x_q, x_d;
    logic [DATA_SIZE_y-1:0] y_q, y_d;
    logic                   sgn_q, sgn_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           p_q, p_d;

    logic [W-1:0]           x_ext;
    logic [W-1:0]           x_sh;
    logic                   y_bit;
    logic                   last_row;
    logic                   neg_row;
    logic                   inj;
    logic [W-1:0]           pp;
    logic [W-1:0]           u;
    logic [W-2:0]           v_lo;

    assign x_ext = signed_i ? {{DATA_SIZE_y{x_i[DATA_SIZE_x-1]}}, x_i}
                            : {{DATA_SIZE_y{1'b0}}, x_i};

    // Current row's partial product; the signed top row is subtracted, its +1
    // riding in carry bit 0, which the carry shift always leaves empty.
    assign x_sh     = x_q << cnt_q;
    assign y_bit    = |(y_q & (DATA_SIZE_y'(1) << cnt_q));
    assign last_row = (cnt_q == CW'(DATA_SIZE_y - 1));
    assign neg_row  = sgn_q & last_row;
    assign pp       = y_bit ? (neg_row ? ~x_sh : x_sh) : '0;
    assign inj      = neg_row & y_bit;

    assign u    = sum_q ^ carry_q ^ pp;
    assign v_lo = (sum_q[W-2:0] & carry_q[W-2:0]) |
                  (sum_q[W-2:0] & pp[W-2:0])      |
                  (carry_q[W-2:0] & pp[W-2:0]);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        x_d     = x_ext;
                        y_d     = y_i;
                        sgn_d   = signed_i;
                        sum_d   = '0;
                        carry_d = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    sum_d   = u;
                    carry_d = {v_lo, inj};
                    cnt_d   = cnt_q + CW'(1);
                    if (last_row) begin
                        state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    p_d     = sum_q + carry_q;
                    state_d = DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign p_o     = p_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Self-checking bench for csa_seq_multiplier: an 8x8 and a 12x4 instance,
// directed vector table, abort/reset sequences and a randomized model sweep.
module tb_csa_seq_multiplier;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic        v8 = 1'b0, r8 = 1'b0, s8 = 1'b0, rdy8, vo8;
    logic [7:0]  x8 = '0, y8 = '0;
    logic [15:0] p8;
    logic [1:0]  st8;

    logic        v12 = 1'b0, r12 = 1'b0, s12 = 1'b0, rdy12, vo12;
    logic [11:0] x12 = '0;
    logic [3:0]  y12 = '0;
    logic [15:0] p12;
    logic [1:0]  st12;

    csa_seq_multiplier #(.DATA_SIZE_x(8), .DATA_SIZE_y(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(v8), .ready_o(rdy8),
        .signed_i(s8), .x_i(x8), .y_i(y8), .valid_o(vo8), .ready_i(r8),
        .p_o(p8), .state_o(st8)
    );

    csa_seq_multiplier #(.DATA_SIZE_x(12), .DATA_SIZE_y(4)) dut12 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(v12), .ready_o(rdy12),
        .signed_i(s12), .x_i(x12), .y_i(y12), .valid_o(vo12), .ready_i(r12),
        .p_o(p12), .state_o(st12)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: interpret operands as integers and multiply, keep low 16 bits.
    function automatic logic [15:0] ref_mul(input longint xv, input longint yv, input bit s,
                                            input int xw, input int yw);
        longint a = xv;
        longint b = yv;
        if (s && a >= (longint'(1) << (xw - 1))) a = a - (longint'(1) << xw);
        if (s && b >= (longint'(1) << (yw - 1))) b = b - (longint'(1) << yw);
        return 16'(a * b);
    endfunction

    // ---------------- drivers ----------------
    // Called at posedge+1 with the 8x8 DUT idle; returns at posedge+1, idle again.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit s,
                       input logic [15:0] exp, input int hold, input string name);
        int lat;
        check({name, "_ready_before"}, rdy8, 1);
        v8 = 1'b1; x8 = x; y8 = y; s8 = s;
        @(posedge clk); #1;
        v8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); s8 = 1'($urandom);
        lat = 0;
        while (!vo8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 9);
        check({name, "_p"}, p8, exp);
        repeat (hold) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, vo8, 1);
            check({name, "_hold_ready"}, rdy8, 0);
            check({name, "_hold_p"}, p8, exp);
        end
        r8 = 1'b1;
        @(posedge clk); #1;
        r8 = 1'b0;
        check({name, "_after_valid"}, vo8, 0);
        check({name, "_after_ready"}, rdy8, 1);
        check({name, "_after_p"}, p8, exp);
    endtask

    task automatic op12(input logic [11:0] x, input logic [3:0] y, input bit s,
                        input logic [15:0] exp, input string name);
        int lat;
        v12 = 1'b1; x12 = x; y12 = y; s12 = s;
        @(posedge clk); #1;
        v12 = 1'b0; x12 = 12'($urandom); y12 = 4'($urandom); s12 = 1'($urandom);
        lat = 0;
        while (!vo12 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 5);
        check({name, "_p"}, p12, exp);
        r12 = 1'b1;
        @(posedge clk); #1;
        r12 = 1'b0;
        check({name, "_after_ready"}, rdy12, 1);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        bit          s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit seen;
        logic [7:0] rx, ry;
        logic [11:0] rx12;
        logic [3:0] ry12;
        bit rs;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[3] = '{8'h01, 8'hFF, 1'b1, 16'hFFFF};
        vecs[4] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        vecs[5] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 16'h03A8};

        // reset state
        @(posedge clk); #1;
        check("rst_ready8", rdy8, 1);
        check("rst_valid8", vo8, 0);
        check("rst_p8", p8, 0);
        check("rst_ready12", rdy12, 1);
        check("rst_valid12", vo12, 0);
        check("rst_p12", p12, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 8; i++) op8(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].exp, 0, $sformatf("vec%0d", i));

        // zero product with back-pressure
        op8(8'h00, 8'hA5, 1'b0, 16'h0000, 5, "zero_bp");

        // non-square widths
        op12(12'hFFF, 4'hF, 1'b0, 16'hEFF1, "w12_unsigned");
        op12(12'hFFF, 4'hF, 1'b1, 16'h0001, "w12_signed");
        op12(12'h800, 4'h8, 1'b1, 16'h4000, "w12_minneg");

        // abort in ACCUM at row 3
        op8(8'h12, 8'h34, 1'b0, 16'h03A8, 0, "pre_abort");
        v8 = 1'b1; x8 = 8'h55; y8 = 8'h33; s8 = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort_ready", rdy8, 1);
        check("abort_valid", vo8, 0);
        check("abort_p_kept", p8, 16'h03A8);
        // clear beats valid in IDLE
        clear = 1'b1; v8 = 1'b1; x8 = 8'h0F; y8 = 8'h0F;
        @(posedge clk); #1;
        clear = 1'b0; v8 = 1'b0;
        check("clear_blocks_accept", rdy8, 1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (vo8) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        check("abort_p_still", p8, 16'h03A8);
        op8(8'd3, 8'd5, 1'b0, 16'd15, 0, "after_abort");

        // async reset mid-ACCUM
        v8 = 1'b1; x8 = 8'h77; y8 = 8'h99; s8 = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_ready", rdy8, 1);
        check("async_valid", vo8, 0);
        check("async_p", p8, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h0B, 8'hF3, 1'b1, ref_mul(8'h0B, 8'hF3, 1'b1, 8, 8), 0, "post_reset");

        // randomized sweep
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
            if ($urandom_range(0, 9) == 0) rx = rs ? 8'h80 : 8'hFF;
            if ($urandom_range(0, 9) == 0) ry = rs ? 8'h80 : 8'hFF;
            op8(rx, ry, rs, ref_mul(longint'(rx), longint'(ry), rs, 8, 8),
                $urandom_range(0, 2), $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 200; i++) begin
            rx12 = 12'($urandom); ry12 = 4'($urandom); rs = 1'($urandom);
            op12(rx12, ry12, rs, ref_mul(longint'(rx12), longint'(ry12), rs, 12, 4),
                 $sformatf("rnd12_%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
